// File: rtl/etapa_fetch_pkg.sv
// Shared definitions for the instruction-fetch stage: default widths,
// the HLT encoding and the fetch state encoding.
package etapa_fetch_pkg;

    localparam int          ANCHO_DIR_DEF  = 10;
    localparam int          ANCHO_INST_DEF = 32;
    localparam logic [31:0] INST_HLT_DEF   = 32'h0000_0000;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } estado_e;

endpackage

// File: rtl/registro_if_id.sv
// Generic pipeline register with valid bit: reset/flush clear, hold freezes,
// bubble drops only the valid bit, otherwise the new entry is captured.
module registro_if_id #(
    parameter int ANCHO = 52
) (
    input  logic             clk,
    input  logic             reset_i,
    input  logic             flush_i,
    input  logic             hold_i,
    input  logic             bubble_i,
    input  logic [ANCHO-1:0] datos_i,
    output logic [ANCHO-1:0] datos_o,
    output logic             valido_o
);

    logic [ANCHO-1:0] datos_q, datos_d;
    logic             valido_q, valido_d;

    always_comb begin
        datos_d  = datos_q;
        valido_d = valido_q;
        if (reset_i || flush_i) begin
            datos_d  = '0;
            valido_d = 1'b0;
        end else if (!hold_i) begin
            if (bubble_i) begin
                valido_d = 1'b0;
            end else begin
                datos_d  = datos_i;
                valido_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        datos_q  <= datos_d;
        valido_q <= valido_d;
    end

    assign datos_o  = datos_q;
    assign valido_o = valido_q;

endmodule

// File: rtl/etapa_fetch.sv
// Instruction-fetch stage: PC, next-PC mux toward a synchronous-read memory,
// and the IF/ID register. HLT detection/halting is built only with FETCH_HLT_EN.
module etapa_fetch
    import etapa_fetch_pkg::*;
#(
    parameter int                    ANCHO_DIR  = ANCHO_DIR_DEF,
    parameter int                    ANCHO_INST = ANCHO_INST_DEF,
    parameter logic [ANCHO_DIR-1:0]  PC_RESET   = '0,
    parameter logic [ANCHO_INST-1:0] INST_HLT   = INST_HLT_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic [ANCHO_DIR-1:0]  direccion,
    input  logic [ANCHO_INST-1:0] instruccion_mem,
    input  logic                  stall,
    input  logic                  salto,
    input  logic [ANCHO_DIR-1:0]  destino,
    output logic [ANCHO_INST-1:0] instruccion,
    output logic [ANCHO_DIR-1:0]  pc_out,
    output logic [ANCHO_DIR-1:0]  pc_mas1,
    output logic                  valido,
    output logic                  detenido
);

    logic [ANCHO_DIR-1:0] pc_q, pc_inc;
    estado_e              estado_q;
    logic                 es_hlt, entra_halt;

`ifdef FETCH_HLT_EN
    assign es_hlt   = (instruccion_mem == INST_HLT);
    assign detenido = (estado_q == HALT);
`else
    logic unused_hlt;
    assign unused_hlt = (instruccion_mem == INST_HLT);
    assign es_hlt     = 1'b0;
    assign detenido   = 1'b0;
`endif

    assign pc_inc     = pc_q + 1'b1;
    assign entra_halt = (estado_q == RUN) && es_hlt && !stall && !salto;

    // The PC also freezes on the edge that enters HALT, so it stays on the HLT word.
    always_comb begin
        if (reset)
            direccion = PC_RESET;
        else if (salto)
            direccion = destino;
        else if (stall || estado_q == HALT || entra_halt)
            direccion = pc_q;
        else
            direccion = pc_inc;
    end

    always_ff @(posedge clk) begin
        pc_q <= direccion;
        if (reset) begin
            estado_q <= RUN;
        end else begin
            case (estado_q)
                RUN:     if (entra_halt) estado_q <= HALT;
                HALT:    if (salto)      estado_q <= RUN;
                default: estado_q <= RUN;
            endcase
        end
    end

    registro_if_id #(
        .ANCHO(ANCHO_INST + 2*ANCHO_DIR)
    ) u_if_id (
        .clk      (clk),
        .reset_i  (reset),
        .flush_i  (salto),
        .hold_i   (stall),
        .bubble_i (estado_q == HALT),
        .datos_i  ({instruccion_mem, pc_q, pc_inc}),
        .datos_o  ({instruccion, pc_out, pc_mas1}),
        .valido_o (valido)
    );

endmodule

// File: tb/tb_etapa_fetch.sv
// Self-checking bench for etapa_fetch: behavioural fetch model compared every
// cycle, directed literal checks, then randomized stall/redirect/reset traffic.
module tb_etapa_fetch;

    localparam int AD = 10;
    localparam int AI = 32;
`ifdef FETCH_HLT_EN
    localparam bit HLT_EN = 1'b1;
`else
    localparam bit HLT_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b1, stall = 1'b0, salto = 1'b0;
    logic [AD-1:0] destino = '0;
    logic [AD-1:0] direccion, pc_out, pc_mas1;
    logic [AI-1:0] instruccion_mem = '0;
    logic [AI-1:0] instruccion;
    logic          valido, detenido;

    logic [AI-1:0] rom [0:1023];
    int            checks = 0, failures = 0;
    bit            armed = 1'b0;

    // Reference model: architectural PC, halt flag and expected IF/ID entry.
    logic [AD-1:0] m_pc = '0, m_pcout = '0, m_pcm1 = '0, m_nxt;
    logic [AI-1:0] m_inst = '0, m_cur;
    bit            m_val = 1'b0, m_halt = 1'b0, m_h;

    etapa_fetch #(
        .ANCHO_DIR (AD),
        .ANCHO_INST(AI),
        .PC_RESET  (10'd0),
        .INST_HLT  (32'h0000_0000)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .direccion      (direccion),
        .instruccion_mem(instruccion_mem),
        .stall          (stall),
        .salto          (salto),
        .destino        (destino),
        .instruccion    (instruccion),
        .pc_out         (pc_out),
        .pc_mas1        (pc_mas1),
        .valido         (valido),
        .detenido       (detenido)
    );

    always #5 clk = ~clk;

    always @(posedge clk) instruccion_mem <= rom[direccion];

    function automatic bit hlt_now();
        return HLT_EN && !m_halt && (rom[m_pc] == '0) && !stall && !salto;
    endfunction

    function automatic logic [AD-1:0] exp_dir();
        if (reset) return '0;
        if (salto) return destino;
        if (stall || m_halt || hlt_now()) return m_pc;
        return AD'((int'(m_pc) + 1) % 1024);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        if (reset) begin
            m_pc = '0; m_halt = 1'b0; m_inst = '0; m_pcout = '0; m_pcm1 = '0; m_val = 1'b0;
            armed = 1'b1;
        end else begin
            m_cur = rom[m_pc];
            m_h   = hlt_now();
            m_nxt = exp_dir();
            if (salto) begin
                m_val = 1'b0; m_inst = '0;
            end else if (!stall) begin
                if (m_halt) m_val = 1'b0;
                else begin
                    m_inst  = m_cur;
                    m_pcout = m_pc;
                    m_pcm1  = AD'((int'(m_pc) + 1) % 1024);
                    m_val   = 1'b1;
                end
            end
            m_halt = m_halt ? !salto : m_h;
            m_pc   = m_nxt;
        end
    end

    always @(negedge clk) begin
        #1;
        if (armed) begin
            chk("valido",      32'(valido),    32'(m_val));
            chk("instruccion", instruccion,    m_inst);
            chk("detenido",    32'(detenido),  32'(m_halt));
            chk("direccion",   32'(direccion), 32'(exp_dir()));
            if (m_val) begin
                chk("pc_out",  32'(pc_out),  32'(m_pcout));
                chk("pc_mas1", 32'(pc_mas1), 32'(m_pcm1));
            end
        end
    end

    // Inputs are applied for exactly one rising edge; returns just after it.
    task automatic cyc(input bit r, input bit st, input bit sa, input int de);
        @(negedge clk);
        reset = r; stall = st; salto = sa; destino = AD'(de);
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) rom[i] = $urandom | 32'h1;
        rom[4] = '0;
        for (int i = 100; i < 1000; i++) if ($urandom_range(0, 31) == 0) rom[i] = '0;

        cyc(1, 0, 0, 0);
        cyc(1, 0, 0, 0);
        chk("rst_valido",    32'(valido),    32'd0);
        chk("rst_inst",      instruccion,    32'd0);
        chk("rst_pc_out",    32'(pc_out),    32'd0);
        chk("rst_pc_mas1",   32'(pc_mas1),   32'd0);
        chk("rst_detenido",  32'(detenido),  32'd0);
        chk("rst_direccion", 32'(direccion), 32'd0);

        cyc(0, 0, 0, 0);
        chk("run0_pc_out", 32'(pc_out), 32'd0);
        chk("run0_valido", 32'(valido), 32'd1);
        chk("run0_inst",   instruccion, rom[0]);
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);
        chk("run3_pc_out",  32'(pc_out),  32'd3);
        chk("run3_pc_mas1", 32'(pc_mas1), 32'd4);
        cyc(0, 0, 0, 0);
        chk("hlt_pc_out", 32'(pc_out), 32'd4);
        chk("hlt_inst",   instruccion, 32'd0);
        chk("hlt_valido", 32'(valido), 32'd1);
        cyc(0, 0, 0, 0);
`ifdef FETCH_HLT_EN
        chk("halt_detenido", 32'(detenido), 32'd1);
        chk("halt_valido",   32'(valido),   32'd0);
        cyc(0, 0, 0, 0);
        chk("halt_frozen_dir", 32'(direccion), 32'd4);
        chk("halt_detenido2",  32'(detenido),  32'd1);
`else
        chk("nohlt_pc_out",   32'(pc_out),   32'd5);
        chk("nohlt_valido",   32'(valido),   32'd1);
        chk("nohlt_detenido", 32'(detenido), 32'd0);
`endif

        cyc(0, 0, 1, 8);
        chk("redir_flush",    32'(valido),   32'd0);
        chk("redir_detenido", 32'(detenido), 32'd0);
        cyc(0, 0, 0, 0);
        chk("redir_pc_out", 32'(pc_out), 32'd8);
        chk("redir_valido", 32'(valido), 32'd1);
        chk("redir_inst",   instruccion, rom[8]);

        for (int i = 0; i < 3; i++) begin
            cyc(0, 1, 0, 0);
            chk("stall_pc_out", 32'(pc_out), 32'd8);
            chk("stall_valido", 32'(valido), 32'd1);
        end
        cyc(0, 0, 0, 0);
        chk("unstall_pc9",  32'(pc_out), 32'd9);
        cyc(0, 0, 0, 0);
        chk("unstall_pc10", 32'(pc_out), 32'd10);

        cyc(0, 1, 1, 20);
        chk("saltostall_flush", 32'(valido), 32'd0);
        cyc(0, 0, 0, 0);
        chk("saltostall_pc_out", 32'(pc_out), 32'd20);

        cyc(0, 0, 1, 1023);
        cyc(0, 0, 0, 0);
        chk("wrap_pc_out",  32'(pc_out),    32'd1023);
        chk("wrap_pc_mas1", 32'(pc_mas1),   32'd0);
        chk("wrap_dir",     32'(direccion), 32'd1);
        cyc(0, 0, 0, 0);
        chk("wrap_next", 32'(pc_out), 32'd0);

        cyc(0, 0, 1, 1);
        chk("self_flush", 32'(valido), 32'd0);
        cyc(0, 0, 0, 0);
        chk("self_refetch", 32'(pc_out), 32'd1);

        cyc(1, 1, 1, 5);
        chk("midrst_valido", 32'(valido), 32'd0);
        chk("midrst_inst",   instruccion, 32'd0);
        chk("midrst_pc_out", 32'(pc_out), 32'd0);
        cyc(0, 0, 0, 0);
        chk("postrst_pc_out", 32'(pc_out), 32'd0);
        chk("postrst_valido", 32'(valido), 32'd1);

        for (int i = 0; i < 2000; i++)
            cyc($urandom_range(0, 99) == 0, $urandom_range(0, 99) < 25,
                $urandom_range(0, 99) < 10, int'($urandom_range(0, 1023)));
        cyc(0, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
